// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: command-loaded modes stepped by a programmable prescaler, plus heartbeat.
// Optional brightness PWM gating is enabled by defining LED_SEQ_PWM_EN.
module led_seq_ctrl #(
  parameter int BASE_SHIFT = 16,
  parameter int HB_BIT     = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_mode,
  input  logic [3:0] cmd_rate,
  input  logic [7:0] cmd_pattern,
  input  logic       hold,
`ifdef LED_SEQ_PWM_EN
  input  logic [2:0] bright,
`endif
  output logic [7:0] led,
  output logic       ledtest,
  output logic       step_tick
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  localparam logic [2:0] M_OFF    = 3'd0;
  localparam logic [2:0] M_BLINK  = 3'd1;
  localparam logic [2:0] M_CHASE  = 3'd2;
  localparam logic [2:0] M_BOUNCE = 3'd3;
  localparam logic [2:0] M_COUNT  = 3'd4;
  localparam logic [2:0] M_STATIC = 3'd5;

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [3:0]  rate_q, rate_d;
  logic [7:0]  cpat_q, cpat_d;
  logic [7:0]  pat_q, pat_d;
  logic        dir_left_q, dir_left_d;
  logic [31:0] presc_q, presc_d;
  logic        tick_q, tick_d;
  logic [31:0] hb_q, hb_d;
  logic        accept;
  logic [5:0]  shamt;
  logic [31:0] term_cnt;

  function automatic logic [7:0] init_pat(input logic [2:0] mode, input logic [7:0] pat);
    case (mode)
      M_BLINK:  init_pat = 8'hFF;
      M_CHASE:  init_pat = 8'h01;
      M_BOUNCE: init_pat = 8'h01;
      M_STATIC: init_pat = pat;
      default:  init_pat = 8'h00;
    endcase
  endfunction

  assign cmd_ready = (state_q != S_LOAD);
  assign accept    = cmd_valid & cmd_ready;
  assign shamt     = 6'(BASE_SHIFT) + {2'b00, rate_q};
  assign term_cnt  = (32'd1 << shamt) - 32'd1;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rate_d     = rate_q;
    cpat_d     = cpat_q;
    pat_d      = pat_q;
    dir_left_d = dir_left_q;
    presc_d    = presc_q;
    tick_d     = 1'b0;
    hb_d       = hb_q + 32'd1;
    case (state_q)
      S_IDLE: begin
        pat_d   = 8'h00;
        presc_d = 32'd0;
        if (accept) begin
          mode_d  = cmd_mode;
          rate_d  = cmd_rate;
          cpat_d  = cmd_pattern;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        presc_d    = 32'd0;
        pat_d      = init_pat(mode_q, cpat_q);
        dir_left_d = 1'b1;
        state_d    = (mode_q == M_OFF || mode_q > M_STATIC) ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // A new command wins over a coincident terminal count.
        if (accept) begin
          mode_d  = cmd_mode;
          rate_d  = cmd_rate;
          cpat_d  = cmd_pattern;
          state_d = S_LOAD;
        end else if (!hold) begin
          if (presc_q == term_cnt) begin
            presc_d = 32'd0;
            tick_d  = 1'b1;
            case (mode_q)
              M_BLINK: pat_d = ~pat_q;
              M_CHASE: pat_d = {pat_q[6:0], pat_q[7]};
              M_BOUNCE: begin
                if (dir_left_q) begin
                  if (pat_q == 8'h80) begin
                    pat_d      = 8'h40;
                    dir_left_d = 1'b0;
                  end else begin
                    pat_d = pat_q << 1;
                  end
                end else if (pat_q == 8'h01) begin
                  pat_d      = 8'h02;
                  dir_left_d = 1'b1;
                end else begin
                  pat_d = pat_q >> 1;
                end
              end
              M_COUNT: pat_d = pat_q + 8'd1;
              default: pat_d = pat_q;
            endcase
          end else begin
            presc_d = presc_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_OFF;
      rate_q     <= 4'd0;
      cpat_q     <= 8'h00;
      pat_q      <= 8'h00;
      dir_left_q <= 1'b1;
      presc_q    <= 32'd0;
      tick_q     <= 1'b0;
      hb_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rate_q     <= rate_d;
      cpat_q     <= cpat_d;
      pat_q      <= pat_d;
      dir_left_q <= dir_left_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      hb_q       <= hb_d;
    end
  end

  assign step_tick = tick_q;
  assign ledtest   = hb_q[HB_BIT];

`ifdef LED_SEQ_PWM_EN
  // Gate against the next PWM phase so led stays a registered output.
  logic [2:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0] led_q, led_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 3'd1;
    led_d     = pat_d & {8{pwm_cnt_d <= bright}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= 3'd0;
      led_q     <= 8'h00;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;
`else
  assign led = pat_q;
`endif

endmodule
